// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared width helpers and defaults for the pipe drain buffer
//
// Purpose : clog2 helper plus counter/pointer width functions used to size the
//           credit counter, occupancy counter and buffer pointers.
// Ports   : none (package).
package pipe_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_LATENCY = 1;
  localparam int DEFAULT_DEPTH   = 4;

  // Ceiling log2, never below 1 so every derived vector has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Credits and occupancy both count 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Pointers index 0..depth-1.
  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_DEPTH);
  localparam int DEFAULT_PTR_W = ptr_w(DEFAULT_DEPTH);

endpackage

// File: rtl/pipe_valid_tracker.sv
// rtl/pipe_valid_tracker.sv - valid shift register shadowing the upstream pipeline
//
// Purpose : LATENCY-bit shift register; bit 0 captures in_fire, the last bit is
//           pipe_valid, i.e. high exactly when pipe_data carries an issued word.
// Ports   : clk, rst (async, active-high), clear (sync clear), in_fire,
//           pipe_valid (tracker tail), valid_bits (whole tracker, for in-flight count).
module pipe_valid_tracker #(
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_fire,
  output logic               pipe_valid,
  output logic [LATENCY-1:0] valid_bits
);

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        valid_bits <= '0;
        else if (clear) valid_bits <= '0;
        else            valid_bits <= in_fire;
      end
    end else begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        valid_bits <= '0;
        else if (clear) valid_bits <= '0;
        else            valid_bits <= {valid_bits[LATENCY-2:0], in_fire};
      end
    end
  endgenerate

  assign pipe_valid = valid_bits[LATENCY-1];

endmodule

// File: rtl/pipe_drain_buffer.sv
// rtl/pipe_drain_buffer.sv - credit-controlled FWFT buffer behind a non-stallable pipeline
//
// Purpose : issues at most DEPTH credits to the producer so every word leaving the
//           fixed-latency pipeline has a guaranteed slot, then presents the buffered
//           words to a valid/ready consumer (first-word fall-through, no bypass).
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready        producer issue handshake (credit available)
//           pipe_data                last pipeline stage data
//           out_valid/out_ready      consumer handshake, out_data = head word
//           occupancy                words stored
//           flush                    sync flush, only with PIPE_DRAIN_FLUSH_EN defined
// Config  : PIPE_DRAIN_FLUSH_EN adds the flush input and its clearing logic.
module pipe_drain_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        pipe_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [cnt_w(DEPTH)-1:0] occupancy
`ifdef PIPE_DRAIN_FLUSH_EN
  ,
  input  logic                    flush
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [CW-1:0]      credits;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LATENCY-1:0] valid_bits;
  logic               pipe_valid;
  logic               in_fire;
  logic               out_fire;
  logic               flush_i;

`ifdef PIPE_DRAIN_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (credits != '0) && !flush_i;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (occupancy != '0);
  assign out_fire  = out_valid && out_ready;
  // Forced to zero when empty so a stale slot is never shown to the consumer.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  pipe_valid_tracker #(
    .LATENCY (LATENCY)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush_i),
    .in_fire    (in_fire),
    .pipe_valid (pipe_valid),
    .valid_bits (valid_bits)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits   <= CW'(DEPTH);
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (flush_i) begin
      // Flush wins over a same-cycle write or read; in-flight credits come back
      // because the tracker is cleared in the same edge.
      credits   <= CW'(DEPTH);
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (in_fire && !out_fire)      credits <= credits - 1'b1;
      else if (!in_fire && out_fire) credits <= credits + 1'b1;

      if (pipe_valid && !out_fire)      occupancy <= occupancy + 1'b1;
      else if (!pipe_valid && out_fire) occupancy <= occupancy - 1'b1;

      if (pipe_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (out_fire)   rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage needs no reset: out_data masks empty slots.
  always_ff @(posedge clk) begin
    if (pipe_valid && !flush_i) mem[wr_ptr] <= pipe_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(pipe_valid && !flush_i && (occupancy == CW'(DEPTH)) && !out_fire));

  a_credit_balance : assert property (@(posedge clk) disable iff (rst)
    (int'(credits) + $countones(valid_bits) + int'(occupancy)) == DEPTH);

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// tb/tb_pipe_drain_buffer.sv - scoreboard bench for pipe_drain_buffer
module tb_pipe_drain_buffer;

  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int DEP = 5;
  localparam int OW  = $clog2(DEP + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [W-1:0]  pipe_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [OW-1:0] occupancy;
  logic          flush;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_drain_buffer #(
    .WIDTH   (W),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pipe_data (pipe_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_DRAIN_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream fixed-latency pipeline emulation (shares rst with the DUT).
  logic [W-1:0] pstage [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pstage[i] <= '0;
    end else begin
      pstage[0] <= in_data;
      for (int i = 1; i < LAT; i++) pstage[i] <= pstage[i-1];
    end
  end
  assign pipe_data = pstage[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: credit count, arrival times of in-flight words, stored count,
  // and the expected data order.
  int           m_cred = DEP;
  int           m_stored = 0;
  int           m_arrive[$];
  logic [W-1:0] exp_q[$];
  int           cyc = 0;

  initial begin
    logic         fin, fout, arr;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_cred = DEP;
        m_stored = 0;
        m_arrive.delete();
        exp_q.delete();
      end else begin
        check("in_ready",  in_ready,  (m_cred != 0) && !flush);
        check("out_valid", out_valid, m_stored != 0);
        check("occupancy", occupancy, m_stored);
        if (m_stored == 0) check("out_data_idle", out_data, 0);
        fin  = in_valid && (m_cred != 0) && !flush;
        fout = out_ready && (m_stored != 0);
        if (flush) begin
          m_cred = DEP;
          m_stored = 0;
          m_arrive.delete();
          exp_q.delete();
        end else begin
          if (fout) begin
            if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
            else begin
              e = exp_q.pop_front();
              check("out_data", out_data, e);
            end
          end
          arr = (m_arrive.size() > 0) && (m_arrive[0] == cyc);
          if (arr) void'(m_arrive.pop_front());
          if (fin) begin
            exp_q.push_back(in_data);
            m_arrive.push_back(cyc + LAT);
          end
          m_stored = m_stored + int'(arr) - int'(fout);
          m_cred   = m_cred + int'(fout) - int'(fin);
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int fires, outs, t_first, t_full, k;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, 0);
    step();

    // Fill with consumer stalled: exactly DEP issues, then no credit.
    in_valid = 1'b1; out_ready = 1'b0;
    fires = 0; t_first = -1; t_full = -1;
    for (int i = 0; i < DEP + LAT + 6; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) begin
        fires++;
        if (t_first < 0) t_first = i;
      end
      if (occupancy == OW'(DEP) && t_full < 0) t_full = i;
      step();
    end
    check("fill_fires", fires, DEP);
    check("fill_time", t_full - t_first, DEP + LAT);
    @(negedge clk);
    check("fill_in_ready", in_ready, 0);
    step();

    // Release consumer: credit visible the cycle after the first out_fire.
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("drain_first_fire", out_valid && !in_ready, 1);
    @(negedge clk);
    check("drain_credit_back", in_ready, 1);
    k = 0;
    while (occupancy != 0 && k < 50) begin @(negedge clk); k++; end
    check("drain_done", occupancy, 0);
    step();

    // Streaming: one word per cycle once filled.
    in_valid = 1'b1; out_ready = 1'b1; outs = 0;
    for (int i = 0; i < 60; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (i >= 20 && out_valid && out_ready) outs++;
      step();
    end
    check("stream_rate", outs, 40);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEP + LAT + 10) step();
    check("random_drained", exp_q.size(), 0);

    // Reset with 2 words in flight and 3 stored.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_occupancy", occupancy, 3);
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_occupancy", occupancy, 0);
    check("post_rst_in_ready", in_ready, 1);
    step();
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 1) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      in_data   = $urandom;
      step();
    end

`ifdef PIPE_DRAIN_FLUSH_EN
    // Flush coincident with a pipeline arrival and an out_fire.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin in_data = $urandom; step(); end
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_busy", out_valid, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("flush_occupancy", occupancy, 0);
    check("flush_in_ready_back", in_ready, 1);
    step();
    in_valid = 1'b1; fires = 0;
    for (int i = 0; i < DEP + LAT + 4; i++) begin
      in_data = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) fires++;
      step();
    end
    check("flush_credits", fires, DEP);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEP + LAT + 6) step();
`endif

    // Final drain with bounded wait.
    in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (occupancy == 0 && exp_q.size() == 0) seen = 1'b1;
    end
    check("final_empty", seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
